// File: rtl/sram_responder_pkg.sv
// Shared constants, pin-cycle decode and counter helper for the SRAM responder.
// Pin encodings are active-low: a pin at PIN_IDLE means "not asserted".
package sram_responder_pkg;

    localparam int   MAX_READ_LATENCY = 4;
    localparam int   COUNT_BITS       = 16;
    localparam logic PIN_ACTIVE       = 1'b0;
    localparam logic PIN_IDLE         = 1'b1;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_WRITE,
        CYC_READ,
        CYC_CONTEND
    } cycle_e;

    // Contention (oe_n and we_n both low) still counts as a write, but never as a read.
    function automatic cycle_e decode_cycle(input logic ce_n, input logic we_n, input logic oe_n);
        if (ce_n == PIN_IDLE)
            return CYC_IDLE;
        if (we_n == PIN_ACTIVE && oe_n == PIN_ACTIVE)
            return CYC_CONTEND;
        if (we_n == PIN_ACTIVE)
            return CYC_WRITE;
        if (oe_n == PIN_ACTIVE)
            return CYC_READ;
        return CYC_IDLE;
    endfunction

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (v == {COUNT_BITS{1'b1}}) ? v : v + COUNT_BITS'(1);
    endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Fixed-depth shift pipe carrying read requests (valid, decoded address, fault mask)
// from issue to the output stage; only the valid bits are cleared by reset.
module sram_read_pipe #(
    parameter int LATENCY   = 1,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [DATA_BITS-1:0] in_mask,
    output logic                 out_valid,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [DATA_BITS-1:0] out_mask
);

    localparam int ADDR_ALL = LATENCY * ADDR_BITS;
    localparam int MASK_ALL = LATENCY * DATA_BITS;

    logic [LATENCY-1:0]  valid_q;
    logic [ADDR_ALL-1:0] addr_q;
    logic [MASK_ALL-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (!reset)
            valid_q <= '0;
        else
            valid_q <= LATENCY'({valid_q, in_valid});
    end

    // Payload needs no reset: it is ignored while its valid bit is clear.
    always_ff @(posedge clk) begin
        addr_q <= ADDR_ALL'({addr_q, in_addr});
        mask_q <= MASK_ALL'({mask_q, in_mask});
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_addr  = addr_q[ADDR_ALL-1 -: ADDR_BITS];
    assign out_mask  = mask_q[MASK_ALL-1 -: DATA_BITS];

endmodule

// File: rtl/sram_responder.sv
// Clocked model of an async SRAM seen from its pins: end-of-pulse write commit,
// pipelined reads with fault injection, saturating counters and a sticky contention flag.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_BITS     = 20,
    parameter int DATA_BITS     = 16,
    parameter int MEM_ADDR_BITS = 8,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_BITS-1:0]     addr_bus,
    inout  wire  [DATA_BITS-1:0]     data_bus,
    input  logic                     we_n,
    input  logic                     oe_n,
    input  logic                     ce_n,
    input  logic                     fault_en,
    input  logic [MEM_ADDR_BITS-1:0] fault_addr,
    input  logic [DATA_BITS-1:0]     fault_mask,
    output logic [COUNT_BITS-1:0]    write_count,
    output logic [COUNT_BITS-1:0]    read_count,
    output logic                     contention
);

    localparam int LAT = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                         (READ_LATENCY < 1)                ? 1 : READ_LATENCY;

    logic [DATA_BITS-1:0]     mem [2**MEM_ADDR_BITS];
    logic [MEM_ADDR_BITS-1:0] dec_addr;
    logic [MEM_ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0]     wr_data;
    logic                     wr_pend;
    logic                     capture;
    logic                     commit;
    logic                     issue;
    logic [DATA_BITS-1:0]     issue_mask;
    logic                     rd_valid;
    logic [MEM_ADDR_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0]     rd_mask;
    logic [DATA_BITS-1:0]     rd_data;
    logic                     drive;
    logic                     unused_addr_hi;
    cycle_e                   pin_cycle;

    assign unused_addr_hi = ^addr_bus[ADDR_BITS-1:MEM_ADDR_BITS];

    // Pin decode; the upper address bits alias onto the backing store.
    always_comb begin
        pin_cycle  = decode_cycle(ce_n, we_n, oe_n);
        dec_addr   = addr_bus[MEM_ADDR_BITS-1:0];
        capture    = (pin_cycle == CYC_WRITE) || (pin_cycle == CYC_CONTEND);
        commit     = wr_pend && !capture;
        issue      = (pin_cycle == CYC_READ);
        issue_mask = (fault_en && dec_addr == fault_addr) ? fault_mask : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_pend     <= 1'b0;
            write_count <= '0;
            read_count  <= '0;
            contention  <= 1'b0;
        end else begin
            if (capture)
                wr_pend <= 1'b1;
            else if (commit) begin
                wr_pend     <= 1'b0;
                write_count <= sat_inc(write_count);
            end
            if (issue)
                read_count <= sat_inc(read_count);
            if (pin_cycle == CYC_CONTEND)
                contention <= 1'b1;
        end
    end

    // Last captured word of a write pulse wins; it is latched when the pulse ends.
    always_ff @(posedge clk) begin
        if (capture) begin
            wr_addr <= dec_addr;
            wr_data <= data_bus;
        end
        if (reset && commit)
            mem[wr_addr] <= wr_data;
    end

    sram_read_pipe #(
        .LATENCY   (LAT),
        .ADDR_BITS (MEM_ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_read_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_addr   (dec_addr),
        .in_mask   (issue_mask),
        .out_valid (rd_valid),
        .out_addr  (rd_addr),
        .out_mask  (rd_mask)
    );

    // The array is read at the output stage, so a commit on the issue edge is always seen.
    assign rd_data  = mem[rd_addr] ^ rd_mask;
    assign drive    = rd_valid && (oe_n == PIN_ACTIVE) && (ce_n == PIN_ACTIVE) && (we_n == PIN_IDLE);
    assign data_bus = drive ? rd_data : 'z;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: latency-2 and latency-3 instances share the pins; a
// scoreboard queue per instance holds expected read words until their due cycle.
module tb_sram_responder;

    localparam int AB = 20;
    localparam int DB = 16;
    localparam int MB = 8;

    typedef struct {
        logic          run;
        logic          ce_n;
        logic          we_n;
        logic          oe_n;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        logic          fen;
        logic [MB-1:0] faddr;
        logic [DB-1:0] fmask;
        logic [DB-1:0] exp_rd;
        logic          chk;
    } vec_t;

    typedef struct {
        int            due;
        logic [DB-1:0] data;
        logic          chk;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AB-1:0] addr_bus;
    logic          we_n, oe_n, ce_n, fault_en;
    logic [MB-1:0] fault_addr;
    logic [DB-1:0] fault_mask;
    logic          drive_en;
    logic [DB-1:0] drive_data;
    wire  [DB-1:0] data_bus2;
    wire  [DB-1:0] data_bus3;
    logic [15:0]   wc2, rc2, wc3, rc3;
    logic          cont2, cont3;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic          bus_check = 1'b0;
    logic          cnt_check = 1'b0;
    exp_t          q2[$];
    exp_t          q3[$];
    logic          m_pend = 1'b0;
    logic [15:0]   m_wc = '0;
    logic [15:0]   m_rc = '0;
    logic          m_cont = 1'b0;
    vec_t          tbl[$];

    always #5 clk = ~clk;

    assign data_bus2 = drive_en ? drive_data : 'z;
    assign data_bus3 = drive_en ? drive_data : 'z;

    sram_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .MEM_ADDR_BITS(MB), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(data_bus2),
        .we_n(we_n), .oe_n(oe_n), .ce_n(ce_n), .fault_en(fault_en),
        .fault_addr(fault_addr), .fault_mask(fault_mask),
        .write_count(wc2), .read_count(rc2), .contention(cont2)
    );

    sram_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .MEM_ADDR_BITS(MB), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(data_bus3),
        .we_n(we_n), .oe_n(oe_n), .ce_n(ce_n), .fault_en(fault_en),
        .fault_addr(fault_addr), .fault_mask(fault_mask),
        .write_count(wc3), .read_count(rc3), .contention(cont3)
    );

    function automatic vec_t mk(input logic c, input logic w, input logic o,
                                input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [DB-1:0] e);
        vec_t v;
        v.run = 1'b1; v.ce_n = c; v.we_n = w; v.oe_n = o;
        v.addr = a; v.data = d; v.fen = 1'b0; v.faddr = '0; v.fmask = '0;
        v.exp_rd = e; v.chk = 1'b1;
        return v;
    endfunction

    function automatic vec_t wr(input logic [AB-1:0] a, input logic [DB-1:0] d);
        return mk(1'b0, 1'b0, 1'b1, a, d, '0);
    endfunction

    function automatic vec_t rd(input logic [AB-1:0] a, input logic [DB-1:0] e);
        return mk(1'b0, 1'b1, 1'b0, a, '0, e);
    endfunction

    function automatic vec_t rdf(input logic [AB-1:0] a, input logic [DB-1:0] e,
                                 input logic [MB-1:0] fa, input logic [DB-1:0] fm);
        vec_t v;
        v = rd(a, e);
        v.fen = 1'b1; v.faddr = fa; v.fmask = fm;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b1, 1'b1, 1'b1, '0, '0, '0);
    endfunction

    function automatic logic released(input logic [DB-1:0] v);
        return $isunknown(v) || (v == '0);
    endfunction

    task automatic compare(input string name, input logic [DB-1:0] act, input logic [DB-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    task automatic compare_released(input string name, input logic [DB-1:0] act);
        total++;
        if (!released(act)) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %h expected Z", name, cyc, act);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset      = v.run;
        ce_n       = v.ce_n;
        we_n       = v.we_n;
        oe_n       = v.oe_n;
        addr_bus   = v.addr;
        fault_en   = v.fen;
        fault_addr = v.faddr;
        fault_mask = v.fmask;
        drive_en   = !v.we_n;
        drive_data = v.data;
    endtask

    task automatic check_output();
        exp_t e2, e3;
        logic gate_on, due2, due3;
        gate_on = (ce_n == 1'b0) && (oe_n == 1'b0) && (we_n == 1'b1);
        if (cnt_check) begin
            compare("write_count2", wc2, m_wc);
            compare("read_count2", rc2, m_rc);
            compare("contention2", 16'(cont2), 16'(m_cont));
            compare("write_count3", wc3, m_wc);
            compare("read_count3", rc3, m_rc);
            compare("contention3", 16'(cont3), 16'(m_cont));
        end
        due2 = 1'b0;
        due3 = 1'b0;
        if (q2.size() > 0 && q2[0].due == cyc) begin e2 = q2.pop_front(); due2 = 1'b1; end
        if (q3.size() > 0 && q3[0].due == cyc) begin e3 = q3.pop_front(); due3 = 1'b1; end
        if (bus_check && !drive_en) begin
            if (due2 && gate_on) begin
                if (e2.chk) compare("read_data2", data_bus2, e2.data);
            end else
                compare_released("bus_z2", data_bus2);
            if (due3 && gate_on) begin
                if (e3.chk) compare("read_data3", data_bus3, e3.data);
            end else
                compare_released("bus_z3", data_bus3);
        end
    endtask

    // Reference behaviour for the cycle whose pins are currently applied.
    task automatic model_update(input vec_t v);
        if (!v.run) begin
            q2.delete();
            q3.delete();
            m_pend = 1'b0;
            m_wc = '0;
            m_rc = '0;
            m_cont = 1'b0;
            return;
        end
        if (v.ce_n == 1'b0 && v.we_n == 1'b0) begin
            m_pend = 1'b1;
            if (v.oe_n == 1'b0) m_cont = 1'b1;
        end else begin
            if (m_pend) begin
                m_pend = 1'b0;
                if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            end
            if (v.ce_n == 1'b0 && v.oe_n == 1'b0) begin
                if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
                q2.push_back('{cyc + 2, v.exp_rd, v.chk});
                q3.push_back('{cyc + 3, v.exp_rd, v.chk});
            end
        end
    endtask

    task automatic run_cycle(input vec_t v);
        apply_stimulus(v);
        @(negedge clk);
        check_output();
        model_update(v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t v;
        apply_stimulus(idle());
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 2; i++) begin
            v = idle();
            v.run  = 1'b0;
            v.ce_n = 1'($urandom_range(0, 1));
            v.we_n = 1'($urandom_range(0, 1));
            v.oe_n = 1'($urandom_range(0, 1));
            v.addr = 20'($urandom);
            v.data = 16'($urandom);
            run_cycle(v);
        end
        bus_check = 1'b1;
        cnt_check = 1'b1;

        tbl.push_back(idle());
        tbl.push_back(wr(20'h00012, 16'hA5A5));
        tbl.push_back(rd(20'h00012, 16'hA5A5));
        tbl.push_back(rd(20'h00012, 16'hA5A5));
        tbl.push_back(rd(20'h00012, 16'hA5A5));
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(wr(20'h00105, 16'h1234));
        tbl.push_back(idle());
        tbl.push_back(wr(20'h00006, 16'hBEEF));
        tbl.push_back(idle());
        tbl.push_back(rd(20'h00005, 16'h1234));
        tbl.push_back(rd(20'h00006, 16'hBEEF));
        tbl.push_back(rdf(20'h00005, 16'h1235, 8'h05, 16'h0001));
        tbl.push_back(rdf(20'h00006, 16'hBEEF, 8'h05, 16'h0001));
        tbl.push_back(rd(20'h00005, 16'h1234));
        tbl.push_back(rdf(20'h00105, 16'h9234, 8'h05, 16'h8000));
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(rd(20'h00005, 16'h1234));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 20'h00005, '0, '0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 20'h00005, '0, '0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        foreach (tbl[i]) run_cycle(tbl[i]);

        $display("[TB] contention sequence");
        run_cycle(mk(1'b0, 1'b0, 1'b0, 20'h00020, 16'h00FF, '0));
        for (int i = 0; i < 3; i++) run_cycle(idle());
        for (int i = 0; i < 4; i++) run_cycle(rd(20'h00020, 16'h00FF));
        for (int i = 0; i < 3; i++) run_cycle(idle());

        $display("[TB] reset during read sequence");
        run_cycle(rd(20'h00005, 16'h1234));
        v = rd(20'h00005, 16'h1234);
        v.run = 1'b0;
        run_cycle(v);
        for (int i = 0; i < 4; i++) run_cycle(rd(20'h00006, 16'hBEEF));
        for (int i = 0; i < 5; i++) run_cycle(idle());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Synthesizable, clocked model of the far end of the async SRAM pin interface. It samples addr_bus/data_bus/we_n/oe_n/ce_n as driven by the SRAM controller and answers reads from a small internal backing store after a configurable latency. Used on-chip, or in simulation, to exercise the tester and controller without a physical SRAM. It supports deterministic fault injection and protocol-violation detection so that the tester's fail path can also be exercised.

Parameters:
ADDR_BITS, 20, width of addr_bus.
DATA_BITS, 16, width of data_bus and of each memory word.
MEM_ADDR_BITS, 8, backing-store depth is 2^MEM_ADDR_BITS; only addr_bus[MEM_ADDR_BITS-1:0] is decoded, so higher bits alias.
READ_LATENCY, 1, cycles from read issue to data driven; legal range 1..4.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
addr_bus  in  ADDR_BITS  SRAM address pins
data_bus  inout  DATA_BITS  SRAM data pins; driven only during read output, else Z
we_n  in  1  write enable, active-low
oe_n  in  1  output enable, active-low
ce_n  in  1  chip enable, active-low
fault_en  in  1  enables read fault injection
fault_addr  in  MEM_ADDR_BITS  decoded address to corrupt
fault_mask  in  DATA_BITS  XOR mask applied to faulted reads
write_count  out  16  saturating count of committed writes
read_count  out  16  saturating count of issued reads
contention  out  1  sticky flag: oe_n and we_n both low with ce_n low

Behaviour:
- Reset (reset==0 at a clk edge): read pipeline valid bits cleared, data_bus Z next cycle, write_count=0, read_count=0, contention=0, pending write dropped. Memory contents are not cleared; reads of unwritten locations are undefined.
- Sampling: pins are used as present at each clk edge. No synchronizer; the block shares the controller's clock.
- Write capture: every cycle with ce_n==0 && we_n==0, wr_addr<=addr_bus[MEM_ADDR_BITS-1:0], wr_data<=data_bus, wr_pend<=1.
- Write commit: on the first cycle where wr_pend==1 and (we_n==1 || ce_n==1), mem[wr_addr]<=wr_data, wr_pend<=0, write_count+=1 (saturates at 0xFFFF). This is the end-of-pulse latch, as in a real async SRAM.
- Read issue: every cycle with ce_n==0 && oe_n==0 && we_n==1, push {valid=1, addr} into a READ_LATENCY-deep shift pipe and read_count+=1 (saturating). Other cycles push valid=0.
- Read data: the pipe's last stage drives data_bus = mem[addr] ^ (fault_en && addr==fault_addr ? fault_mask : 0). The output enable is the last stage's valid bit AND oe_n==0 AND ce_n==0 sampled in the current cycle, so releasing oe_n tri-states the bus in the next cycle. fault_en, fault_addr and fault_mask are sampled at issue time.
- Forwarding: a read issued in the same cycle as a write commit to the same decoded address returns the newly committed data. No stale read is ever returned after a commit.
- Address change while oe_n is held low: each cycle is an independent issue, giving one new word per cycle after the initial latency.
- Contention: ce_n==0 && oe_n==0 && we_n==0 sets contention=1, which holds until reset. The write is captured, no read is issued, and the bus is not driven.
- ce_n==1: no capture and no issue. The pipe continues to drain, but the bus stays Z because of the ce_n gate.
- Counters never wrap.

Decomposition:
- Shared header sram_defs.vh holds:
  - the MAX_READ_LATENCY (=4) constant;
  - the counter width (16);
  - the pin-level encodings, with active-low idle values ce_n=1, we_n=1, oe_n=1.
- One natural sub-module, sram_read_pipe: a parameterized READ_LATENCY-stage shift register of {valid, MEM_ADDR_BITS address, fault fields}, with synchronous active-low clear.
- Memory array, write capture/commit, forwarding mux and tri-state driver stay in sram_responder.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random pins -> data_bus Z, write_count=0, read_count=0, contention=0.
- Write/read, READ_LATENCY=2:
  - stimulus: ce_n=0, we_n=0 with addr_bus=0x00012 and data 0xA5A5 for 1 cycle, then we_n=1; then oe_n=0 at 0x00012;
  - response: write_count=1, and data_bus=0xA5A5 exactly 2 cycles after issue;
  - then oe_n=1 -> bus Z on the next cycle.
- Aliasing, MEM_ADDR_BITS=8: write 0x1234 at 0x00105, then read 0x00005 -> 0x1234.
- Fault:
  - stimulus: fault_en=1, fault_addr=0x05, fault_mask=0x0001;
  - response: read of 0x00005 returns 0x1235; read of 0x00006 returns its true value;
  - fault_en=0 -> read of 0x00005 returns 0x1234.
- Contention: ce_n=0, oe_n=0, we_n=0 with data 0x00FF at 0x00020 -> contention=1 and stays 1, bus Z; the subsequent read of 0x00020 returns 0x00FF.
- Reset mid-read, READ_LATENCY=3: issue a read, assert reset=0 one cycle later, release -> data_bus stays Z for all following cycles and read_count=0.
